count_event_stamper: RTL and testbench
======================================

# count_event_stamper

Timestamp capture stage downstream of the 16-bit free-running counter. Rising edges on `event_in` capture the current `count` value, plus a flag recording whether the counter wrapped since the previous capture. Captured stamps go into a small FIFO, which the consumer drains over a valid/ready handshake. Loss of events on a full FIFO is reported by a sticky overflow flag.

## Interface

Parameters:
- `CW`, 16, count width; must equal the upstream counter width.
- `DEPTH`, 4, FIFO entries; must be a power of 2, minimum 2.

Ports:
- `clock`  in  1  clock; all logic on posedge.
- `resetN`  in  1  reset, asynchronous, active-low.
- `count`  in  CW  free-running count from the upstream counter, synchronous to `clock`.
- `event_in`  in  1  synchronous event level; a capture occurs on its 0→1 transition.
- `ts_ready`  in  1  consumer accepts the head entry.
- `clear_ovf`  in  1  synchronous clear of `overflow`.
- `ts_valid`  out  1  FIFO non-empty; head entry presented.
- `ts_data`  out  CW  head timestamp.
- `ts_wrap`  out  1  head entry saw at least one counter wrap since the previous accepted capture.
- `overflow`  out  1  sticky; set when an event is dropped.
- `level`  out  $clog2(DEPTH)+1  current number of stored entries.

## Operation

- **Edge detect:** register `event_d`. `cap = event_in & ~event_d`. A held-high `event_in` yields exactly one capture; a new capture requires at least one low cycle.
- **Wrap tracking:**
  - Register `prev_count`. `wrap_now = (count < prev_count)`, unsigned compare.
  - `wrap_pend` is set by `wrap_now`.
  - On an accepted capture, the stored wrap bit = `wrap_pend | wrap_now`, and `wrap_pend` clears.
  - On a dropped capture, `wrap_pend` is kept, or set if `wrap_now` is true.
- **Stored entry:** `{wrap, count}`, using `count` as sampled at the capture edge.
- **FIFO:**
  - Circular buffer with read/write pointers one bit wider than the index.
  - `push = cap & (~full | pop)`.
  - `pop = ts_valid & ts_ready`.
- **Full with simultaneous pop and cap:** both happen; `level` stays at DEPTH.
- **Full, no pop, cap:** the event is dropped, `overflow` is set, and FIFO contents are unchanged.
- **Empty with cap:** no bypass; the entry appears the following cycle.
- **Overflow clear:** `clear_ovf` clears `overflow`. A drop in the same cycle wins, so `overflow` stays 1.
- **Output format:** first-word-fall-through. While `ts_valid` is 0, `ts_data` and `ts_wrap` are driven 0.
- **Pop on empty:** ignored; there is no underflow.
- **Reset values:**
  - All outputs are 0.
  - Pointers, `event_d`, `prev_count`, `wrap_pend` and `overflow` are 0.
  - Storage contents don't care.

## Timing

- Capture latency: `event_in` rises before edge k, so `cap` is evaluated at edge k. The entry is written at edge k, and `ts_valid`/`ts_data` reflect it after edge k, i.e. one cycle.
- Pop: with `ts_valid & ts_ready` high at edge k, the next entry, or `ts_valid` = 0, is presented after edge k.
- `level`, `overflow` and `ts_valid` are registered outputs.
- Throughput: one push and one pop per cycle.
- Reset mid-operation takes effect immediately, independent of `clock`; the FIFO empties and pending wrap information is lost.
- Deassertion of `resetN` is synchronised externally. First capture is possible at the first edge after release.

## Test plan

1. **Reset:** `resetN`=0 with `event_in` toggling → `ts_valid`=0, `level`=0, `overflow`=0, `ts_data`=0x0000 throughout.
2. **Single event:** `event_in` rises when `count`=0x0010 at the edge → next cycle `ts_valid`=1, `ts_data`=0x0010, `ts_wrap`=0, `level`=1. With `ts_ready`=1, `ts_valid`=0 after the following edge.
3. **Held event:** `event_in` held high for 10 cycles → exactly one entry, `level`=1.
4. **Overflow:**
   - Five separated events with `ts_ready`=0 → `level`=4, `overflow`=1, and the head is still the first stamp.
   - `clear_ovf` pulse → `overflow`=0.
5. **Wrap:** capture at 0xFFF0, counter passes 0xFFFF→0x0000, capture at 0x0005, then capture at 0x0009 → `ts_wrap` reads 0, 1, 0 respectively.
6. **Full-cycle push/pop, then reset:**
   - FIFO full, `ts_ready`=1 and a capture in the same cycle → `level` stays 4, the new stamp lands at the tail, `overflow`=0.
   - Then `resetN` pulled low mid-stream with `level`=3 → `ts_valid`=0 and `level`=0 immediately.

Source files
------------

// File: rtl/count_event_stamper.sv
// Timestamp capture stage: stamps event_in rising edges with the free-running
// count plus a wrap flag, queued in a FWFT FIFO drained over valid/ready.
module count_event_stamper #(
    parameter int CW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic [CW-1:0]            count,
    input  logic                     event_in,
    input  logic                     ts_ready,
    input  logic                     clear_ovf,
    output logic                     ts_valid,
    output logic [CW-1:0]            ts_data,
    output logic                     ts_wrap,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic          event_d;
    logic [CW-1:0] prev_count;
    logic          wrap_pend;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   level_q;
    logic [AW:0]   level_nx;
    logic          valid_q;
    logic          ovf_q;
    logic [CW:0]   mem [DEPTH];
    logic [CW:0]   head;

    logic cap;
    logic wrap_now;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign cap      = event_in & ~event_d;
    assign wrap_now = (count < prev_count);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = valid_q & ts_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = cap & (~full | pop);
    assign drop     = cap & ~push;

    always_comb begin
        level_nx = level_q;
        if (push && !pop) begin
            level_nx = level_q + PTR_ONE;
        end else if (pop && !push) begin
            level_nx = level_q - PTR_ONE;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            event_d    <= 1'b0;
            prev_count <= '0;
            wrap_pend  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            event_d    <= event_in;
            prev_count <= count;
            wrap_pend  <= push ? 1'b0 : (wrap_pend | wrap_now);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level_q <= level_nx;
            valid_q <= (level_nx != '0);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {wrap_pend | wrap_now, count};
        end
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign ts_valid = valid_q;
    assign ts_data  = valid_q ? head[CW-1:0] : '0;
    assign ts_wrap  = valid_q ? head[CW] : 1'b0;
    assign overflow = ovf_q;
    assign level    = level_q;

endmodule

// File: tb/tb_count_event_stamper.sv
// Bench for count_event_stamper: directed plan followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_count_event_stamper;

    localparam int CW    = 16;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          resetN;
    logic [CW-1:0] count;
    logic          event_in;
    logic          ts_ready;
    logic          clear_ovf;
    logic          ts_valid;
    logic [CW-1:0] ts_data;
    logic          ts_wrap;
    logic          overflow;
    logic [2:0]    level;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [CW:0]   m_q[$];
    logic          m_ev_d;
    logic [CW-1:0] m_prev;
    logic          m_pend;
    logic          m_ovf;

    count_event_stamper #(.CW(CW), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .resetN   (resetN),
        .count    (count),
        .event_in (event_in),
        .ts_ready (ts_ready),
        .clear_ovf(clear_ovf),
        .ts_valid (ts_valid),
        .ts_data  (ts_data),
        .ts_wrap  (ts_wrap),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ev_d = 1'b0;
        m_prev = '0;
        m_pend = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Apply the rules of one clock edge to the model using current inputs.
    task automatic model_edge();
        bit cap, wn, pop, dropped;
        if (!resetN) begin
            model_reset();
            return;
        end
        cap     = event_in && !m_ev_d;
        wn      = count < m_prev;
        pop     = (m_q.size() > 0) && ts_ready;
        dropped = 0;
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back({m_pend | wn, count});
                m_pend = 1'b0;
            end else begin
                dropped = 1;
                m_pend  = m_pend | wn;
            end
        end else begin
            m_pend = m_pend | wn;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clear_ovf) m_ovf = 1'b0;
        m_ev_d = event_in;
        m_prev = count;
    endtask

    task automatic compare_all(input string tag);
        logic [CW:0] h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        chk({tag, ".valid"}, 32'(ts_valid), 32'(m_q.size() > 0));
        chk({tag, ".level"}, 32'(level), 32'(m_q.size()));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".data"}, 32'(ts_data), 32'(h[CW-1:0]));
        chk({tag, ".wrap"}, 32'(ts_wrap), 32'(h[CW]));
    endtask

    // One clock: inputs already set; model steps at the edge, check at +1.
    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
        count = count + 16'd1;
    endtask

    initial begin
        resetN    = 1'b0;
        count     = '0;
        event_in  = 1'b0;
        ts_ready  = 1'b0;
        clear_ovf = 1'b0;
        model_reset();

        // reset with event toggling
        for (int i = 0; i < 4; i++) begin
            event_in = ~event_in;
            step("rst");
            chk("rst.data0", 32'(ts_data), 32'h0);
        end
        event_in = 1'b0;
        resetN   = 1'b1;
        step("rel");

        // single event at 0x0010
        count    = 16'h0010;
        event_in = 1'b1;
        step("single");
        chk("single.data", 32'(ts_data), 32'h0010);
        chk("single.lvl", 32'(level), 32'd1);
        event_in = 1'b0;
        ts_ready = 1'b1;
        step("single.pop");
        chk("single.gone", 32'(ts_valid), 32'd0);

        // held event yields one entry
        ts_ready = 1'b0;
        event_in = 1'b1;
        for (int i = 0; i < 10; i++) step("held");
        chk("held.lvl", 32'(level), 32'd1);
        event_in = 1'b0;
        ts_ready = 1'b1;
        step("held.drain");

        // overflow: five separated events
        ts_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            event_in = 1'b1;
            step("ovf.ev");
            event_in = 1'b0;
            step("ovf.gap");
        end
        chk("ovf.lvl", 32'(level), 32'd4);
        chk("ovf.flag", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        step("ovf.clr");
        clear_ovf = 1'b0;
        chk("ovf.cleared", 32'(overflow), 32'd0);

        // full with simultaneous pop and capture
        ts_ready = 1'b1;
        event_in = 1'b1;
        step("full.pp");
        chk("full.lvl", 32'(level), 32'd4);
        chk("full.ovf", 32'(overflow), 32'd0);
        event_in = 1'b0;
        step("full.pop");
        ts_ready = 1'b0;
        step("full.idle");
        chk("full.lvl3", 32'(level), 32'd3);

        // asynchronous reset mid-stream
        resetN = 1'b0;
        #1;
        chk("arst.valid", 32'(ts_valid), 32'd0);
        chk("arst.lvl", 32'(level), 32'd0);
        model_reset();
        step("arst");
        resetN = 1'b1;
        step("arst.rel");

        // wrap sequence: captures at 0xFFF0, 0x0005, 0x0009
        ts_ready = 1'b1;
        count    = 16'hFFF0;
        event_in = 1'b1;
        step("wrap.a");
        chk("wrap.a", 32'(ts_wrap), 32'd0);
        event_in = 1'b0;
        while (count != 16'h0005) step("wrap.run");
        event_in = 1'b1;
        step("wrap.b");
        chk("wrap.b", 32'(ts_wrap), 32'd1);
        event_in = 1'b0;
        while (count != 16'h0009) step("wrap.run2");
        event_in = 1'b1;
        step("wrap.c");
        chk("wrap.c", 32'(ts_wrap), 32'd0);
        event_in = 1'b0;
        step("wrap.end");

        // random traffic including count jumps to provoke wraps
        for (int i = 0; i < 600; i++) begin
            event_in  = ($urandom_range(0, 2) == 0);
            ts_ready  = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
            clear_ovf = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) count = 16'($urandom);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
